// File: rtl/thread_fetch.sv
// Per-thread instruction fetch: owns the PC and a small return-address stack,
// issues reads to a synchronous instruction memory and hands words to decode.
module thread_fetch #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ins,
  output logic [PC_W-1:0] ins_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  input  logic            isJump,
  input  logic [PC_W-1:0] jumpAddr,
  input  logic            setTOS,
  input  logic            pop,
  input  logic            isHalted,
  output logic            halted,
  output logic            stack_ovf,
  output logic            stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state_q;
  logic              pending_q;     // read issued last cycle, data on imem_rdata now
  logic              hold_valid_q;  // word parked because decode stalled
  logic [31:0]       hold_ins_q;
  logic [PC_W-1:0]   pc_q;          // address of the word in flight or presented
  logic [SP_W-1:0]   sp_q;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];
  logic              halted_q;
  logic              ovf_q;
  logic              unf_q;

  logic              accept;
  logic              unf_err;
  logic              ovf_err;
  logic              stop;
  logic [PC_W-1:0]   ret_pc;
  logic [PC_W-1:0]   tos;
  logic [PC_W-1:0]   target_d;
  logic [SP_W-1:0]   sp_m1;
  logic [SP_W-1:0]   sp_pop_d;
  logic [IDX_W-1:0]  tos_idx;
  logic [IDX_W-1:0]  push_idx;

  assign ins_valid = pending_q | hold_valid_q;
  assign ins       = hold_valid_q ? hold_ins_q : (pending_q ? imem_rdata : 32'd0);
  assign ins_pc    = pc_q;
  assign halted    = halted_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

  assign accept   = ins_valid & ins_ready;
  assign ret_pc   = pc_q + PC_W'(1);
  assign sp_m1    = sp_q - SP_W'(1);
  assign tos_idx  = sp_m1[IDX_W-1:0];
  assign tos      = stack_q[tos_idx];
  assign sp_pop_d = pop ? sp_m1 : sp_q;
  assign push_idx = sp_pop_d[IDX_W-1:0];

  // A halt request masks every other control, including stack errors.
  assign unf_err = ~isHalted & pop & (sp_q == '0);
  assign ovf_err = ~isHalted & ~pop & setTOS & (sp_q == SP_W'(STACK_DEPTH));
  assign stop    = isHalted | unf_err | ovf_err;

  always_comb begin
    target_d = ret_pc;
    if (pop)         target_d = tos;
    else if (isJump) target_d = jumpAddr;
  end

  always_comb begin
    imem_en   = 1'b0;
    imem_addr = '0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          imem_en   = 1'b1;
          imem_addr = start_pc;
        end
      end
      RUN: begin
        if (accept && !stop) begin
          imem_en   = 1'b1;
          imem_addr = target_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_ins_q   <= '0;
      pc_q         <= '0;
      sp_q         <= '0;
      halted_q     <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pending_q <= imem_en;
      if (imem_en) pc_q <= imem_addr;
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            sp_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
          end
        end
        RUN: begin
          // Park the returning word so ins stays stable while imem_rdata moves.
          if (pending_q && !ins_ready) begin
            hold_valid_q <= 1'b1;
            hold_ins_q   <= imem_rdata;
          end
          if (accept) begin
            hold_valid_q <= 1'b0;
            if (stop) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
              if (ovf_err) ovf_q <= 1'b1;
              if (unf_err) unf_q <= 1'b1;
            end else if (setTOS) begin
              stack_q[push_idx] <= ret_pc;
              sp_q              <= sp_pop_d + SP_W'(1);
            end else begin
              sp_q <= sp_pop_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thread_fetch.sv
// Randomized scoreboard bench for thread_fetch: a program-level model predicts
// the (pc, word) stream and final halt/error status for each run.
module tb_thread_fetch;
  localparam int PC_W  = 10;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] start_pc = '0;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic [31:0]     ins;
  logic [PC_W-1:0] ins_pc;
  logic            ins_valid;
  logic            ins_ready = 1'b0;
  logic            isJump, setTOS, pop, isHalted;
  logic [PC_W-1:0] jumpAddr;
  logic            halted, stack_ovf, stack_unf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  thread_fetch #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .isJump(isJump), .jumpAddr(jumpAddr), .setTOS(setTOS), .pop(pop),
    .isHalted(isHalted), .halted(halted), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  // Instruction memory: synchronous read, garbage when not enabled.
  logic [31:0] mem [1024];
  always @(posedge clk) imem_rdata <= imem_en ? mem[imem_addr] : $urandom;

  // Toy decoder: [31]=halt [30]=pop [29]=jump [28]=setTOS [9:0]=jump target.
  always @(*) begin
    isHalted = ins[31];
    pop      = ins[30];
    isJump   = ins[29];
    setTOS   = ins[28];
    jumpAddr = ins[PC_W-1:0];
  end

  // 0: always ready, 1: random ready, 2: ready one cycle in four.
  int ready_mode = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: ins_ready = 1'b1;
      1: ins_ready = ($urandom_range(0, 9) < 7);
      default: begin
        ins_ready = (stall_cnt == 3);
        stall_cnt = (stall_cnt + 1) % 4;
      end
    endcase
  end

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     w;
  } exp_t;
  exp_t exp_q[$];
  bit open_run = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, expv, $time);
    end
  endtask

  // Program-level model: run from spc until halt or max_steps instructions.
  task automatic run_model(input logic [PC_W-1:0] spc, input int max_steps,
                           output bit halts, output bit ovf, output bit unf);
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] nxt;
    logic [PC_W-1:0] stk[$];
    logic [31:0]     w;
    exp_t            e;
    pc = spc;
    halts = 0; ovf = 0; unf = 0;
    for (int s = 0; s < max_steps && !halts; s++) begin
      w = mem[pc];
      e.pc = pc;
      e.w  = w;
      exp_q.push_back(e);
      if (w[31]) halts = 1;
      else if (w[30] && stk.size() == 0) begin halts = 1; unf = 1; end
      else if (!w[30] && w[28] && stk.size() == DEPTH) begin halts = 1; ovf = 1; end
      else begin
        if (w[30])      nxt = stk.pop_back();
        else if (w[29]) nxt = w[PC_W-1:0];
        else            nxt = pc + 10'd1;
        if (w[28]) stk.push_back(pc + 10'd1);
        pc = nxt;
      end
    end
  endtask

  // Monitor: compares every accepted word against the scoreboard.
  bit prev_acc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_acc = 0;
    end else begin
      if (prev_acc) check("zero_bubble_valid", {31'd0, ins_valid}, 32'd1);
      prev_acc = 0;
      if (ins_valid && !ins_ready) check("stall_no_fetch", {31'd0, imem_en}, 32'd0);
      if (ins_valid && ins_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("accept pc=%h ins=%h", ins_pc, ins);
          check("ins_pc", {22'd0, ins_pc}, {22'd0, e.pc});
          check("ins", ins, e.w);
          prev_acc = (exp_q.size() > 0);
        end else if (!open_run) begin
          check("unexpected_accept", 32'd1, 32'd0);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ins_valid"}, {31'd0, ins_valid}, 32'd0);
    check({tag, "_ins"}, ins, 32'd0);
    check({tag, "_ins_pc"}, {22'd0, ins_pc}, 32'd0);
    check({tag, "_imem_en"}, {31'd0, imem_en}, 32'd0);
    check({tag, "_imem_addr"}, {22'd0, imem_addr}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_ovf"}, {31'd0, stack_ovf}, 32'd0);
    check({tag, "_unf"}, {31'd0, stack_unf}, 32'd0);
  endtask

  task automatic do_start(input logic [PC_W-1:0] pc);
    @(negedge clk);
    start = 1'b1;
    start_pc = pc;
    @(posedge clk);
    #1 start = 1'b0;
    start_pc = $urandom;
    @(negedge clk);
    check("first_valid", {31'd0, ins_valid}, 32'd1);
    check("start_halted_clr", {31'd0, halted}, 32'd0);
    check("start_ovf_clr", {31'd0, stack_ovf}, 32'd0);
    check("start_unf_clr", {31'd0, stack_unf}, 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic reset_mid();
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    open_run = 0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", {31'd0, ins_valid}, 32'd0);
      check("post_rst_ins", ins, 32'd0);
      check("post_rst_imem_en", {31'd0, imem_en}, 32'd0);
    end
  endtask

  task automatic episode(input logic [PC_W-1:0] spc, input int steps, input int mode);
    bit h, o, u;
    ready_mode = mode;
    run_model(spc, steps, h, o, u);
    open_run = !h;
    $display("run start_pc=%h steps=%0d mode=%0d halts=%0d ovf=%0d unf=%0d",
             spc, steps, mode, h, o, u);
    do_start(spc);
    wait_drain();
    if (h) begin
      @(posedge clk);
      @(negedge clk);
      check("halted", {31'd0, halted}, 32'd1);
      check("halt_valid_low", {31'd0, ins_valid}, 32'd0);
      check("stack_ovf", {31'd0, stack_ovf}, {31'd0, o});
      check("stack_unf", {31'd0, stack_unf}, {31'd0, u});
      repeat (3) begin
        @(negedge clk);
        check("halt_no_fetch", {31'd0, imem_en}, 32'd0);
      end
    end else begin
      reset_mid();
    end
  endtask

  function automatic logic [31:0] rand_word();
    int r;
    logic [31:0] w;
    r = $urandom_range(0, 99);
    w = $urandom;
    if (r < 60)      w[31:28] = 4'h0;
    else if (r < 70) w[31:28] = 4'h2;
    else if (r < 78) w[31:28] = 4'h3;
    else if (r < 88) w[31:28] = 4'h4;
    else if (r < 91) w[31:28] = 4'h5;
    else if (r < 95) w[31:28] = 4'h1;
    else             w[31] = 1'b1;
    return w;
  endfunction

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = {4'h0, 28'(k)};
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("idle");

    // Sequential fetch across the top of the address space.
    episode(10'h3FE, 4, 0);
    // Decode held off three cycles per word.
    episode(10'h100, 6, 2);

    // Call at 0x010 into 0x100, return to 0x011, then a pop on the now-empty stack.
    mem[10'h010] = 32'h3000_0100;
    mem[10'h101] = 32'h4000_0000;
    mem[10'h013] = 32'h4000_0000;
    episode(10'h00E, 20, 0);

    // Five nested calls; the fifth overflows the four-entry stack.
    for (int i = 0; i < 5; i++) mem[10'h200 + i] = 32'h3000_0000 | (32'h201 + 32'(i));
    episode(10'h200, 20, 1);

    // Halt at 0x020, restart from HALTED (errors cleared), then restart at 0x040.
    mem[10'h020] = 32'h8000_0000;
    episode(10'h01E, 10, 0);
    episode(10'h040, 5, 1);

    for (int ep = 0; ep < 25; ep++) begin
      for (int k = 0; k < 1024; k++) mem[k] = rand_word();
      episode(10'($urandom), $urandom_range(10, 60), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/thread_fetch.md
Name: thread_fetch

Overview:
- Per-thread instruction fetch stage directly upstream of instructionDecode.
- Owns the thread PC and a small return-address stack. Issues reads to a synchronous instruction memory and presents 32-bit instruction words to decode over a valid/ready handshake.
- Decode's resolved control outputs (isJump, jumpAddr, setTOS, pop, isHalted) feed back on the accept cycle to select the next PC.
- Sustains 1 instruction/cycle when decode is ready.

Parameters:
- PC_W, 10, PC/jump address width; matches jumpAddr.
- STACK_DEPTH, 4, return-stack entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin execution at start_pc; honoured only in IDLE or HALTED.
- start_pc  in  PC_W  entry address.
- imem_en  out  1  instruction-memory read enable (combinational).
- imem_addr  out  PC_W  read address (combinational).
- imem_rdata  in  32  read data, valid the cycle after imem_en.
- ins  out  32  instruction to decode.
- ins_pc  out  PC_W  address of ins.
- ins_valid  out  1  ins is valid.
- ins_ready  in  1  decode accepts ins this cycle.
- isJump  in  1  from decode, sampled on accept.
- jumpAddr  in  PC_W  from decode, sampled on accept.
- setTOS  in  1  from decode; push ins_pc+1, sampled on accept.
- pop  in  1  from decode; return to TOS, sampled on accept.
- isHalted  in  1  from decode, sampled on accept.
- halted  out  1  thread stopped; level.
- stack_ovf  out  1  sticky push-when-full error.
- stack_unf  out  1  sticky pop-when-empty error.

Behaviour:
- Reset (async, rst_n=0), all outputs and state low/zero:
  - state=IDLE, pc=0, sp=0.
  - ins=0, ins_pc=0, ins_valid=0.
  - halted=0, stack_ovf=0, stack_unf=0.
  - imem_en=0, imem_addr=0.
- Reset mid-operation discards the in-flight fetch and stack contents. An imem_rdata returning after reset is ignored.
- States: IDLE, RUN, HALTED.
  - IDLE: imem_en=0. On start: imem_en=1, imem_addr=start_pc, sp cleared, errors cleared, go to RUN.
  - HALTED: halted=1, ins_valid=0. start behaves as in IDLE (clears halted, stack and errors); all other inputs ignored.
- Fetch timing:
  - Read issued in cycle N → ins_valid=1 in cycle N+1 with ins=imem_rdata and ins_pc=issued address.
  - If not accepted in N+1, the word is captured in a hold register. ins and ins_pc stay stable until accept (imem_rdata may change).
  - At most one fetch is in flight. No fetch is issued while ins_valid && !ins_ready.
- Accept (ins_valid && ins_ready) selects the next PC. Priority (highest first):
  1. isHalted: no fetch; ins_valid=0 next cycle; go to HALTED. Other controls ignored.
  2. pop: target=stack[sp-1], sp-1. Empty stack: stack_unf=1, no fetch, go to HALTED.
  3. isJump: target=jumpAddr.
  4. default: target=ins_pc+1 modulo 2^PC_W (0x3FF wraps to 0x000).
- Unless halting, accept issues imem_en=1, imem_addr=target in the same cycle, so the next ins_valid follows the next cycle (zero-bubble, jumps included).
- setTOS on accept pushes ins_pc+1 (wrapped), applied after any pop in the same accept:
  - pop+setTOS replaces TOS; target is the old TOS.
  - isJump+setTOS is a call.
  - Push with sp==STACK_DEPTH and no simultaneous pop: stack_ovf=1, no push, no fetch, go to HALTED.
- Accept without ready-side stall keeps ins_valid=1 continuously.
- ins_valid deasserts only on halt or in IDLE/HALTED.
- Error flags stay set until reset or start.

Test Plan:
- Sequential: mem[k]=k-tagged NOPs, start_pc=0x3FE, ins_ready=1 → ins_pc 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; first ins_valid one cycle after start.
- Stall: accept in cycle N is held off for 3 cycles while imem_rdata is toggled → ins and ins_pc unchanged; no imem_en during the stall; next fetch issued on the accept cycle.
- Call/return:
  - At pc 0x010: isJump=1, setTOS=1, jumpAddr=0x100 → next ins_pc=0x100.
  - Later pop → ins_pc=0x011, sp back to 0.
- Overflow/underflow:
  - 5 calls with STACK_DEPTH=4 → fifth sets stack_ovf=1, halted=1, no further imem_en.
  - pop on empty stack → stack_unf=1, halted=1.
- Halt/restart: isHalted accepted at 0x020 → ins_valid=0 next cycle, halted=1. Then start, start_pc=0x040 → halted=0, errors cleared, ins_pc=0x040.
- Reset mid-stream: rst_n low while ins_valid=1 and a fetch is in flight → all outputs zero immediately. Stale imem_rdata is not presented; IDLE until start.
